// File: rtl/bit_serial_adder_pkg.sv
// ============================================================================
// Module   : bit_serial_adder_pkg
// Brief    : Shared ALU package: FSM state encoding, default width, helpers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bit_serial_adder_pkg;

  localparam int c_DEFAULT_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_serial_adder_if.sv
// ============================================================================
// Module   : bit_serial_adder_if
// Brief    : Request/result bundle between a requester and the serial adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface bit_serial_adder_if
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output start, a, b, sub,
    input  busy, done, result, flag_n, flag_z, flag_c, flag_v
  );

  modport slave (
    input  start, a, b, sub,
    output busy, done, result, flag_n, flag_z, flag_c, flag_v
  );

endinterface

`default_nettype wire

// File: rtl/bit_serial_adder_adder.sv
// ============================================================================
// Module   : adder
// Brief    : 1-bit full-adder cell.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adder (
  input  wire logic i_a,
  input  wire logic i_b,
  input  wire logic i_cin,
  output logic      o_sum,
  output logic      o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

`default_nettype wire

// File: rtl/bit_serial_adder.sv
// ============================================================================
// Module   : bit_serial_adder
// Brief    : LSB-first bit-serial add/subtract with NZCV flags, one bit/cycle.
//            Subtraction is enabled by defining SERIAL_ADDER_SUB_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  bit_serial_adder_if.slave bus
);

  localparam int                 c_CNT_W = cnt_width(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic               w_load;
  logic               w_step;
  logic               w_busy;
  logic               w_done;
  logic               w_last;
  logic               w_sub;
  logic               w_sum;
  logic               w_cout;
  logic [WIDTH-1:0]   w_result_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_n;
  logic               r_z;
  logic               r_c;
  logic               r_v;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub = bus.sub;
`else
  assign w_sub = 1'b0;
`endif

  assign w_last = (r_cnt == c_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Start in DONE is accepted on the same edge so operations can chain.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_next = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        w_step = 1'b1;
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_done = 1'b1;
        if (bus.start) begin
          w_load = 1'b1;
          w_next = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  adder u_adder (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign w_result_next = {w_sum, r_result[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
    end else if (w_load) begin
      // Subtraction is a + ~b + 1: invert b and seed the carry.
      r_a     <= bus.a;
      r_b     <= w_sub ? ~bus.b : bus.b;
      r_carry <= w_sub;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_carry  <= w_cout;
      r_result <= w_result_next;
      if (w_last) begin
        r_n <= w_sum;
        r_z <= (w_result_next == '0);
        r_c <= w_cout;
        r_v <= r_carry ^ w_cout;
      end else begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = r_result;
  assign bus.flag_n = r_n;
  assign bus.flag_z = r_z;
  assign bus.flag_c = r_c;
  assign bus.flag_v = r_v;

endmodule

`default_nettype wire

// File: tb/tb_bit_serial_adder.sv
// ============================================================================
// Module   : tb_bit_serial_adder
// Brief    : Directed self-checking bench for bit_serial_adder at WIDTH=8.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bit_serial_adder;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  bit_serial_adder_if #(.WIDTH(W)) bus ();

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] nzcv();
    return {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};
  endfunction

  // Ends on the negedge following the accepting edge.
  task automatic launch(input logic [7:0] x, input logic [7:0] y, input logic s);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    bus.sub   = s;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts edges until done is seen at a negedge (bounded).
  task automatic wait_done(output int edges);
    edges = 0;
    while (bus.done !== 1'b1 && edges < 50) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic op(input string tag, input logic [7:0] x, input logic [7:0] y,
                    input logic s, input logic [7:0] exp_res, input logic [3:0] exp_f);
    int e;
    launch(x, y, s);
    wait_done(e);
    check_val({tag, "_lat"}, 64'(e + 1), 64'd9);
    check_val({tag, "_res"}, 64'(bus.result), 64'(exp_res));
    check_val({tag, "_nzcv"}, 64'(nzcv()), 64'(exp_f));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int          e;
    int          pulses;
    logic [7:0]  seen;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.sub   = 1'b0;

    repeat (2) @(negedge clk);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_done", 64'(bus.done), 64'd0);
    check_val("rst_res", 64'(bus.result), 64'd0);
    check_val("rst_nzcv", 64'(nzcv()), 64'd0);
    rst_n = 1'b1;

    op("add7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1001);
    op("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0110);
    op("add1234", 8'h12, 8'h34, 1'b0, 8'h46, 4'b0000);
    op("add8080", 8'h80, 8'h80, 1'b0, 8'h00, 4'b0111);
`ifdef SERIAL_ADDER_SUB_EN
    op("sub0505", 8'h05, 8'h05, 1'b1, 8'h00, 4'b0110);
    op("sub0305", 8'h03, 8'h05, 1'b1, 8'hFE, 4'b1000);
    op("sub8001", 8'h80, 8'h01, 1'b1, 8'h7F, 4'b0011);
`else
    op("subign", 8'h03, 8'h05, 1'b1, 8'h08, 4'b0000);
`endif

    // Start pulsed during RUN cycle 3 must be ignored.
    launch(8'h10, 8'h20, 1'b0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.start = 1'b1;
    bus.a     = 8'h55;
    bus.b     = 8'h55;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    pulses = 0;
    seen   = '0;
    repeat (20) begin
      if (bus.done === 1'b1) begin
        pulses++;
        seen = bus.result;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check_val("ign_pulses", 64'(pulses), 64'd1);
    check_val("ign_res", 64'(seen), 64'h30);

    // Start held through DONE chains a second operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h02;
    bus.sub   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wait_done(e);
    check_val("b2b_lat1", 64'(e + 1), 64'd9);
    check_val("b2b_res1", 64'(bus.result), 64'h03);
    bus.a = 8'h03;
    bus.b = 8'h04;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check_val("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done(e);
    check_val("b2b_gap", 64'(e + 1), 64'd9);
    check_val("b2b_res2", 64'(bus.result), 64'h07);

    // Reset asserted at RUN bit 4 abandons the operation.
    launch(8'h7F, 8'h01, 1'b0);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_val("mid_busy_pre", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("mid_busy", 64'(bus.busy), 64'd0);
    check_val("mid_done", 64'(bus.done), 64'd0);
    check_val("mid_res", 64'(bus.result), 64'd0);
    check_val("mid_nzcv", 64'(nzcv()), 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    repeat (20) begin
      if (bus.done === 1'b1) pulses++;
      @(posedge clk);
      @(negedge clk);
    end
    check_val("mid_nodone", 64'(pulses), 64'd0);
    check_val("mid_idle", 64'(bus.busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
